// File: rtl/buffer_candidates_ctrl.sv
// Sequencer for the 9-row x DEPTH-stage candidate shift buffer in the FME
// datapath. It pulls reference columns from the fetch unit, drives the
// buffer's shared shift enable, flags a complete candidate window to the
// interpolation/SAD stage and then steps the window by the configured stride.
module buffer_candidates_ctrl #(
    parameter int DEPTH    = 10,
    parameter int CNT_W    = 4,
    parameter int WIN_W    = 8,
    parameter int STRIDE_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [WIN_W-1:0]    cfg_windows,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic                src_valid,
    output logic                src_ready,
    output logic                buf_enable,
    output logic                cand_valid,
    input  logic                dst_ready,
    output logic [WIN_W-1:0]    window_idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2
    } ctrlState_t;

    localparam logic [CNT_W-1:0] LP_DEPTH   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] LP_WIN_ONE = WIN_W'(1);

    ctrlState_t       r_state;
    ctrlState_t       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_need;
    logic [CNT_W-1:0] r_stride;
    logic [WIN_W-1:0] r_windows;
    logic [WIN_W-1:0] r_windowIdx;
    logic             r_done;

    logic             w_shift;
    logic             w_lastColumn;
    logic             w_consume;
    logic             w_lastWindow;
    logic [WIN_W-1:0] w_cfgWindows;
    logic [CNT_W-1:0] w_cfgStride;
    logic [31:0]      w_strideExt;

    // A column shifts only while filling; the buffer is frozen in every other state.
    assign w_shift      = (r_state == FILL) && src_valid;
    assign w_lastColumn = (r_cnt == (r_need - LP_CNT_ONE));
    assign w_consume    = (r_state == VALID) && dst_ready;
    assign w_lastWindow = (r_windowIdx == (r_windows - LP_WIN_ONE));

    // Zero windows or zero stride would never finish, so both floor at one;
    // a stride wider than the buffer just means a full refill.
    assign w_strideExt  = 32'(cfg_stride);
    assign w_cfgWindows = (cfg_windows == '0) ? LP_WIN_ONE : cfg_windows;
    assign w_cfgStride  = (cfg_stride == '0)         ? LP_CNT_ONE :
                          (w_strideExt > 32'(DEPTH)) ? LP_DEPTH   :
                                                       CNT_W'(cfg_stride);

    assign window_idx = r_windowIdx;
    assign done       = r_done;

    // State register; abort is folded into the next-state logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: abort beats any start or consume in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_nextState = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_shift && w_lastColumn) begin
                    w_nextState = VALID;
                end
            end
            VALID: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_consume) begin
                    w_nextState = w_lastWindow ? IDLE : FILL;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the current state.
    always_comb begin
        src_ready  = 1'b0;
        buf_enable = 1'b0;
        cand_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            FILL: begin
                src_ready  = 1'b1;
                buf_enable = src_valid;
                busy       = 1'b1;
            end
            VALID: begin
                cand_valid = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                src_ready  = 1'b0;
            end
        endcase
    end

    // Column counter, window index, held block config and the done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_need      <= LP_DEPTH;
            r_stride    <= LP_CNT_ONE;
            r_windows   <= LP_WIN_ONE;
            r_windowIdx <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_cnt       <= '0;
                r_need      <= LP_DEPTH;
                r_windowIdx <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_windows   <= w_cfgWindows;
                            r_stride    <= w_cfgStride;
                            r_need      <= LP_DEPTH;
                            r_cnt       <= '0;
                            r_windowIdx <= '0;
                        end
                    end
                    FILL: begin
                        if (w_shift) begin
                            r_cnt <= r_cnt + LP_CNT_ONE;
                        end
                    end
                    VALID: begin
                        if (w_consume) begin
                            if (w_lastWindow) begin
                                r_done      <= 1'b1;
                                r_windowIdx <= '0;
                            end else begin
                                r_windowIdx <= r_windowIdx + LP_WIN_ONE;
                                r_need      <= r_stride;
                                r_cnt       <= '0;
                            end
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/buffer_candidates_ctrl.md
Name: buffer_candidates_ctrl

Overview:
- Sequencer for the 9-row x DEPTH-stage candidate shift buffer in the FME datapath.
- Accepts reference-pixel columns from the upstream fetch unit and drives the buffer's shared shift enable.
- Signals when the buffer holds a complete candidate window and waits for the interpolation/SAD stage to consume it.
- Steps the window horizontally by a configurable stride for a configurable number of windows per block.

Parameters:
DEPTH, 10, number of shift stages in the candidate buffer (columns per full window)
CNT_W, 4, width of the internal column counter; must hold DEPTH
WIN_W, 8, width of the window-count configuration and window index
STRIDE_W, 4, width of the stride configuration

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a block (ignored unless idle)
abort  input  1  synchronous abort; returns to IDLE next cycle
cfg_windows  input  WIN_W  windows per block, sampled at start
cfg_stride  input  STRIDE_W  new columns between successive windows, sampled at start
src_valid  input  1  upstream column present on buffer inputs
src_ready  output  1  controller will shift a column this cycle if src_valid
buf_enable  output  1  shift enable to the candidate buffer
cand_valid  output  1  buffer holds a complete window
dst_ready  input  1  consumer accepts the current window
window_idx  output  WIN_W  index of the current/next window, 0-based
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last window is accepted

Behaviour:
- Clock is clock; reset is synchronous and active-high. Reset and abort each force IDLE. All outputs are 0 in IDLE and after reset; window_idx is cleared to 0.
- Config sampling on start in IDLE:
  - Windows: cfg_windows=0 is treated as 1.
  - Stride: cfg_stride=0 is treated as 1; cfg_stride>DEPTH is clamped to DEPTH.
  - Both values are registered and held for the block.
- States: IDLE, FILL, VALID.
- IDLE:
  - On start, go to FILL, set need=DEPTH, cnt=0, window_idx=0.
  - start while busy is ignored.
- FILL:
  - src_ready=1, combinational buf_enable = src_valid & src_ready.
  - Each cycle with buf_enable, cnt increments.
  - When cnt==need-1 and buf_enable, go to VALID next cycle.
  - A src_valid=0 cycle stalls with no shift and no count.
- VALID:
  - cand_valid=1, src_ready=0, buf_enable=0. The buffer contents are frozen.
  - The window is consumed when cand_valid & dst_ready.
  - On consume, if window_idx == windows-1: pulse done next cycle and go to IDLE.
  - Otherwise, window_idx increments, need=stride, cnt=0, and the state goes to FILL.
  - There is no shift in the consume cycle. The first new column is accepted the cycle after.
- Column totals:
  - Total accepted columns per block = DEPTH + (windows-1)*stride.
  - The buf_enable count is exactly this value. No enable is ever issued outside FILL.
- cand_valid rules:
  - cand_valid rises the cycle after the last needed column shifts in, so latency is 1 cycle.
  - It stays high until consumed and never drops without dst_ready, unless reset or abort occurs.
- Priority:
  - reset > abort > normal operation.
  - abort in the same cycle as a consume gives no done pulse.
  - abort in the same cycle as start keeps the controller in IDLE.
- Reset or abort mid-FILL:
  - The partially shifted buffer contents are not cleared by this block.
  - The next block refills all DEPTH columns.
- busy is high in FILL and VALID and low on the cycle done is high.

Test Plan:
- Single window: start with windows=1, stride=1, src_valid held high → buf_enable for exactly 10 consecutive cycles. cand_valid high on cycle 11 and held. dst_ready pulse → done one cycle later, busy=0.
- Strided block: windows=3, stride=2, continuous src_valid and dst_ready=1 → 14 total enables in the pattern 10, 2, 2. window_idx sequences 0,1,2. Three cand_valid pulses, then done.
- Backpressure: in VALID, hold dst_ready=0 for 5 cycles with src_valid=1 → src_ready=0, buf_enable=0, cand_valid steady. Release → FILL resumes the next cycle.
- Source stalls: windows=1, src_valid toggling 1,0 → 10 enables spread over 19 cycles. cand_valid only after the 10th.
- Clamping: cfg_windows=0, cfg_stride=15 → a single window. In a second run with windows=2, stride=15 → second fill is 10 columns (total 20).
- Abort and reset: abort after 4 enables → IDLE next cycle, all outputs 0. Next start requires 10 fresh columns. Reset asserted in VALID → cand_valid=0 the next cycle. start while busy has no effect.
